// File: rtl/sr_pkg.sv
// Shared definitions for the serial-in/parallel-out deserializer.
// Holds the FSM state type and the default word width.
package sr_pkg;

    localparam int SR_WIDTH = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } sr_state_t;

endpackage

// File: rtl/sr_sipo_shift.sv
// WIDTH-bit MSB-first shift register with shift enable and synchronous clear.
// next_word is the value the register takes on an enabled edge.
module sr_sipo_shift
    import sr_pkg::*;
#(
    parameter int WIDTH = SR_WIDTH
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           shift_en,
    input  logic           clear,
    input  logic           din,
    output logic [WIDTH:1] next_word
);

    logic [WIDTH:1] sr;

    // The word completing on this edge is also handed to the output register.
    assign next_word = (sr << 1) | {{(WIDTH-1){1'b0}}, din};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr <= '0;
        end else if (clear) begin
            sr <= '0;
        end else if (shift_en) begin
            sr <= next_word;
        end
    end

endmodule

// File: rtl/sr_sipo_deser.sv
// Serial-to-parallel deserializer: counts bits into words, then offers each
// completed word to a valid/ready output register with a sticky overrun flag.
module sr_sipo_deser
    import sr_pkg::*;
#(
    parameter int WIDTH = SR_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     din,
    input  logic                     din_valid,
    input  logic                     clear,
    output logic [WIDTH:1]           q,
    output logic                     q_valid,
    input  logic                     q_ready,
    output logic                     busy,
    output logic [$clog2(WIDTH):1]   bit_cnt,
    output logic                     overrun
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW:1] LAST_CNT = CW'(WIDTH - 1);

    sr_state_t      state;
    sr_state_t      state_next;
    logic [CW:1]    cnt_next;
    logic           word_done;
    logic           shift_en;
    logic           load_q;
    logic [WIDTH:1] next_word;

    // clear wins over a simultaneous din_valid, so that bit never shifts in.
    assign shift_en = din_valid && !clear;
    assign load_q   = word_done && (!q_valid || q_ready);
    assign busy     = (state == SHIFT);

    sr_sipo_shift #(
        .WIDTH (WIDTH)
    ) u_shift (
        .clk       (clk),
        .reset     (reset),
        .shift_en  (shift_en),
        .clear     (clear),
        .din       (din),
        .next_word (next_word)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            bit_cnt <= '0;
        end else begin
            state   <= state_next;
            bit_cnt <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = bit_cnt;
        word_done  = 1'b0;
        if (clear) begin
            state_next = IDLE;
            cnt_next   = '0;
        end else if (din_valid) begin
            if (bit_cnt == LAST_CNT) begin
                state_next = IDLE;
                cnt_next   = '0;
                word_done  = 1'b1;
            end else begin
                state_next = SHIFT;
                cnt_next   = bit_cnt + CW'(1);
            end
        end
    end

    // A word arriving while the consumer stalls is dropped and flagged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q       <= '0;
            q_valid <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (load_q) begin
                q       <= next_word;
                q_valid <= 1'b1;
            end else if (q_ready) begin
                q_valid <= 1'b0;
            end

            if (clear) begin
                overrun <= 1'b0;
            end else if (word_done && q_valid && !q_ready) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sr_sipo_deser.sv
// Directed testbench for sr_sipo_deser: a per-cycle vector table with
// hand-computed expectations plus hand-written gap, clear and reset sequences.
module tb_sr_sipo_deser;

    logic       clk;
    logic       reset;
    logic       din;
    logic       din_valid;
    logic       clear;
    logic       q_ready;
    logic [8:1] q;
    logic       q_valid;
    logic       busy;
    logic [3:1] bit_cnt;
    logic       overrun;

    int checks;
    int failures;

    typedef struct {
        logic       dv;
        logic       din;
        logic       clr;
        logic       qr;
        logic [7:0] eq;
        logic       eqv;
        logic [2:0] ecnt;
        logic       eovr;
    } vec_t;

    vec_t vecs[$];

    sr_sipo_deser #(
        .WIDTH (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .din_valid (din_valid),
        .clear     (clear),
        .q         (q),
        .q_valid   (q_valid),
        .q_ready   (q_ready),
        .busy      (busy),
        .bit_cnt   (bit_cnt),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void add(input logic dv, input logic d, input logic clr,
                                input logic qr, input logic [7:0] eq, input logic eqv,
                                input logic [2:0] ecnt, input logic eovr);
        vecs.push_back('{dv, d, clr, qr, eq, eqv, ecnt, eovr});
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge and outputs are sampled there too.
    task automatic apply_stimulus(input logic dv, input logic d, input logic clr, input logic qr);
        din_valid = dv;
        din       = d;
        clear     = clr;
        q_ready   = qr;
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [7:0] eq, input logic eqv,
                                input logic [2:0] ecnt, input logic eovr);
        check({tag, " q"}, 32'(q), 32'(eq));
        check({tag, " q_valid"}, 32'(q_valid), 32'(eqv));
        check({tag, " bit_cnt"}, 32'(bit_cnt), 32'(ecnt));
        check({tag, " busy"}, 32'(busy), 32'(ecnt != 3'd0));
        check({tag, " overrun"}, 32'(overrun), 32'(eovr));
    endtask

    initial begin
        logic [7:0] w;
        int         k;
        checks    = 0;
        failures  = 0;
        reset     = 1'b1;
        din       = 1'b0;
        din_valid = 1'b0;
        clear     = 1'b0;
        q_ready   = 1'b0;

        //  dv din clr qr  q      qv cnt ovr
        // basic 8'hA5, q_ready high
        add(1, 1, 0, 1, 8'h00, 0, 1, 0);
        add(1, 0, 0, 1, 8'h00, 0, 2, 0);
        add(1, 1, 0, 1, 8'h00, 0, 3, 0);
        add(1, 0, 0, 1, 8'h00, 0, 4, 0);
        add(1, 0, 0, 1, 8'h00, 0, 5, 0);
        add(1, 1, 0, 1, 8'h00, 0, 6, 0);
        add(1, 0, 0, 1, 8'h00, 0, 7, 0);
        add(1, 1, 0, 1, 8'hA5, 1, 0, 0);
        add(0, 0, 0, 1, 8'hA5, 0, 0, 0);
        // 8'h3C held by a stalled consumer
        add(1, 0, 0, 0, 8'hA5, 0, 1, 0);
        add(1, 0, 0, 0, 8'hA5, 0, 2, 0);
        add(1, 1, 0, 0, 8'hA5, 0, 3, 0);
        add(1, 1, 0, 0, 8'hA5, 0, 4, 0);
        add(1, 1, 0, 0, 8'hA5, 0, 5, 0);
        add(1, 1, 0, 0, 8'hA5, 0, 6, 0);
        add(1, 0, 0, 0, 8'hA5, 0, 7, 0);
        add(1, 0, 0, 0, 8'h3C, 1, 0, 0);
        // 8'hC3 completes on the handshake edge of 8'h3C: no bubble
        add(1, 1, 0, 0, 8'h3C, 1, 1, 0);
        add(1, 1, 0, 0, 8'h3C, 1, 2, 0);
        add(1, 0, 0, 0, 8'h3C, 1, 3, 0);
        add(1, 0, 0, 0, 8'h3C, 1, 4, 0);
        add(1, 0, 0, 0, 8'h3C, 1, 5, 0);
        add(1, 0, 0, 0, 8'h3C, 1, 6, 0);
        add(1, 1, 0, 0, 8'h3C, 1, 7, 0);
        add(1, 1, 0, 1, 8'hC3, 1, 0, 0);
        add(0, 0, 0, 1, 8'hC3, 0, 0, 0);
        // backpressure: 8'h11 held, 8'h22 dropped
        add(1, 0, 0, 0, 8'hC3, 0, 1, 0);
        add(1, 0, 0, 0, 8'hC3, 0, 2, 0);
        add(1, 0, 0, 0, 8'hC3, 0, 3, 0);
        add(1, 1, 0, 0, 8'hC3, 0, 4, 0);
        add(1, 0, 0, 0, 8'hC3, 0, 5, 0);
        add(1, 0, 0, 0, 8'hC3, 0, 6, 0);
        add(1, 0, 0, 0, 8'hC3, 0, 7, 0);
        add(1, 1, 0, 0, 8'h11, 1, 0, 0);
        add(1, 0, 0, 0, 8'h11, 1, 1, 0);
        add(1, 0, 0, 0, 8'h11, 1, 2, 0);
        add(1, 1, 0, 0, 8'h11, 1, 3, 0);
        add(1, 0, 0, 0, 8'h11, 1, 4, 0);
        add(1, 0, 0, 0, 8'h11, 1, 5, 0);
        add(1, 0, 0, 0, 8'h11, 1, 6, 0);
        add(1, 1, 0, 0, 8'h11, 1, 7, 0);
        add(1, 0, 0, 0, 8'h11, 1, 0, 1);
        add(0, 0, 0, 1, 8'h11, 0, 0, 1);
        add(0, 0, 0, 1, 8'h11, 0, 0, 1);
        // three bits, then clear together with din_valid, then 8'h5A
        add(1, 1, 0, 1, 8'h11, 0, 1, 1);
        add(1, 1, 0, 1, 8'h11, 0, 2, 1);
        add(1, 1, 0, 1, 8'h11, 0, 3, 1);
        add(1, 1, 1, 1, 8'h11, 0, 0, 0);
        add(1, 0, 0, 1, 8'h11, 0, 1, 0);
        add(1, 1, 0, 1, 8'h11, 0, 2, 0);
        add(1, 0, 0, 1, 8'h11, 0, 3, 0);
        add(1, 1, 0, 1, 8'h11, 0, 4, 0);
        add(1, 1, 0, 1, 8'h11, 0, 5, 0);
        add(1, 0, 0, 1, 8'h11, 0, 6, 0);
        add(1, 1, 0, 1, 8'h11, 0, 7, 0);
        add(1, 0, 0, 1, 8'h5A, 1, 0, 0);

        repeat (2) @(posedge clk);
        #3;
        check_output("reset", 8'h00, 0, 0, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(vecs[i].dv, vecs[i].din, vecs[i].clr, vecs[i].qr);
            check_output($sformatf("row%0d", i), vecs[i].eq, vecs[i].eqv,
                         vecs[i].ecnt, vecs[i].eovr);
        end

        // clear mid-word leaves a held output word untouched
        for (int i = 0; i < 5; i++) apply_stimulus(1, 1, 0, 0);
        check_output("pre_clear", 8'h5A, 1, 5, 0);
        apply_stimulus(0, 0, 1, 0);
        check_output("clear_keeps_q", 8'h5A, 1, 0, 0);

        // asynchronous reset mid-word and mid-handshake
        for (int i = 0; i < 5; i++) apply_stimulus(1, 0, 0, 0);
        check_output("pre_reset", 8'h5A, 1, 5, 0);
        #2 reset = 1'b1;
        #1;
        check_output("async_reset", 8'h00, 0, 0, 0);
        din_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;

        // first bits after reset start a fresh word
        for (int i = 1; i <= 8; i++) begin
            apply_stimulus(1, 1, 0, 1);
            check($sformatf("ff bit%0d bit_cnt", i), 32'(bit_cnt), 32'(i % 8));
        end
        check_output("ff_word", 8'hFF, 1, 0, 0);

        // 8'hA5 with random idle gaps between bits
        w = 8'hA5;
        k = 0;
        for (int i = 0; i < 8; i++) begin
            int gap;
            gap = int'($urandom_range(0, 5));
            for (int g = 0; g < gap; g++) begin
                apply_stimulus(0, 0, 0, 1);
                check($sformatf("gap b%0d g%0d bit_cnt", i, g), 32'(bit_cnt), 32'(k));
                check($sformatf("gap b%0d g%0d busy", i, g), 32'(busy), 32'(k != 0));
            end
            apply_stimulus(1, w[7-i], 0, 1);
            k = (k + 1) % 8;
            check($sformatf("gap bit%0d bit_cnt", i), 32'(bit_cnt), 32'(k));
            check($sformatf("gap bit%0d busy", i), 32'(busy), 32'(k != 0));
        end
        check("gap q", 32'(q), 32'h0A5);
        check("gap q_valid", 32'(q_valid), 32'd1);
        apply_stimulus(0, 0, 0, 1);
        check("gap q_valid drop", 32'(q_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
